wmem_layer: RTL

WMEM_LAYER -- requirements
Module: wmem_layer

---
 rtl/wmem_pkg.sv | 26 ++
 rtl/wmem_bank.sv | 52 +++++
 rtl/wmem_layer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wmem_pkg
// Brief   : Shared FSM state encoding and address helpers for wmem_layer.
// Revision: 1.0
// ============================================================================
package wmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2
    } wmem_state_e;

    // Address width for an n-entry space, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Row-major flat weight index.
    function automatic int flat_addr(input int h, input int i, input int n_in);
        return h * n_in + i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wmem_bank.sv
`default_nettype none
// ============================================================================
// Module  : wmem_bank
// Brief   : One-write, one-synchronous-read weight bank (read-first).
// Revision: 1.0
// ============================================================================
module wmem_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Storage is deliberately left unreset; the owner zero-fills it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= ({1'b0, rd_addr_i} < C_DEPTH) ? mem_q[rd_addr_i] : '0;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule
`default_nettype wire

// File: rtl/wmem_layer.sv
`default_nettype none
// ============================================================================
// Module  : wmem_layer
// Brief   : Layer weight memory with word write, stream load, zero-fill and
//           N_RD independent synchronous read ports.
// Revision: 1.0
// ============================================================================
module wmem_layer
    import wmem_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  N_IN      = 8,
    parameter int  N_OUT     = 4,
    parameter int  N_RD      = 2,
    localparam int WMEM_SIZE = N_OUT * N_IN,
    localparam int RADDR_W   = addr_w(WMEM_SIZE),
    localparam int H_W       = addr_w(N_OUT),
    localparam int I_W       = addr_w(N_IN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_wr_en,
    input  logic [H_W-1:0]            w_addr_h,
    input  logic [I_W-1:0]            w_addr_i,
    input  logic [DATA_W-1:0]         w_data,
    input  logic                      s_valid,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    input  logic                      clr_start,
    input  logic [N_RD*RADDR_W-1:0]   raddr,
    input  logic [N_RD-1:0]           ren,
    output logic [N_RD*DATA_W-1:0]    rdata,
    output logic [N_RD-1:0]           rvalid,
    output logic                      busy,
    output logic                      load_done,
    output logic                      load_err
);

    localparam logic [RADDR_W-1:0] C_LAST = RADDR_W'(WMEM_SIZE - 1);

    wmem_state_e        state_q, state_d;
    logic [RADDR_W-1:0] ptr_q, ptr_d;
    logic               init_clr_q, init_clr_d;
    logic               load_done_q, load_done_d;
    logic               load_err_q, load_err_d;
    logic               wr_v_q, wr_v_d;
    logic [RADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic               w_busy;
    logic               w_in_range;
    logic [RADDR_W-1:0] w_flat;
    logic               w_fsm_we;
    logic [RADDR_W-1:0] w_fsm_addr;
    logic [DATA_W-1:0]  w_fsm_data;
    logic               w_mem_we;
    logic [RADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0]  w_mem_data;

    assign w_busy     = (state_q != ST_IDLE);
    assign w_in_range = (int'(w_addr_h) < N_OUT) && (int'(w_addr_i) < N_IN);
    assign w_flat     = RADDR_W'(flat_addr(int'(w_addr_h), int'(w_addr_i), N_IN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            init_clr_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            wr_v_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_clr_q  <= init_clr_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            wr_v_q      <= wr_v_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_clr_d  = init_clr_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        w_fsm_we    = 1'b0;
        w_fsm_addr  = ptr_q;
        w_fsm_data  = '0;

        wr_v_d      = w_wr_en && !w_busy && w_in_range;
        wr_addr_d   = w_flat;
        wr_data_d   = w_data;

        case (state_q)
            ST_IDLE: begin
                // The zero-fill of address 0 happens on the entry edge so a
                // full clear spans exactly WMEM_SIZE edges.
                if (init_clr_q || clr_start) begin
                    w_fsm_we   = 1'b1;
                    w_fsm_addr = '0;
                    ptr_d      = RADDR_W'(1);
                    init_clr_d = 1'b0;
                    load_err_d = 1'b0;
                    state_d    = ST_CLEAR;
                end else if (s_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    w_fsm_we   = 1'b1;
                    w_fsm_data = s_data;
                    if (s_last != (ptr_q == C_LAST)) begin
                        load_err_d = 1'b1;
                    end
                    if (s_last || (ptr_q == C_LAST)) begin
                        ptr_d       = '0;
                        load_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + RADDR_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                w_fsm_we = 1'b1;
                if (ptr_q == C_LAST) begin
                    ptr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + RADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM traffic owns the shared write port; a pipelined word write loses.
    assign w_mem_we   = w_fsm_we || wr_v_q;
    assign w_mem_addr = w_fsm_we ? w_fsm_addr : wr_addr_q;
    assign w_mem_data = w_fsm_we ? w_fsm_data : wr_data_q;

    for (genvar g = 0; g < N_RD; g++) begin : g_bank
        wmem_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (WMEM_SIZE),
            .AW     (RADDR_W)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (w_mem_we),
            .wr_addr_i  (w_mem_addr),
            .wr_data_i  (w_mem_data),
            .rd_en_i    (ren[g]),
            .rd_addr_i  (raddr[g*RADDR_W +: RADDR_W]),
            .rd_data_o  (rdata[g*DATA_W +: DATA_W]),
            .rd_valid_o (rvalid[g])
        );
    end

    assign s_ready   = (state_q == ST_LOAD);
    assign busy      = w_busy;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule
`default_nettype wire
